regfile_rename: RTL

- Architectural integer register file for the out-of-order core, with per-register rename status (busy bit plus ROB tag).
- Sits between decode/issue and the reorder buffer.
  - Issue renames destination registers and reads operand values or producer tags over NREAD ports.
  - ROB commit writes results back and releases the rename.
  - Branch mispredict flush clears all renames.

---
 rtl/regfile_rename.sv | 62 ++++++
 1 files changed

// File: rtl/regfile_rename.sv
// regfile_rename: architectural register file with per-register rename busy/tag and commit bypass
module regfile_rename #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 4,
  parameter int NREAD = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   rename_en,
  input  logic [AW-1:0]          rename_rd,
  input  logic [TAG_W-1:0]       rename_tag,
  input  logic                   commit_en,
  input  logic [AW-1:0]          commit_rd,
  input  logic [TAG_W-1:0]       commit_tag,
  input  logic [XLEN-1:0]        commit_value,
  input  logic [NREAD-1:0]       rd_en,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0]  rd_value,
  output logic [NREAD-1:0]       rd_busy,
  output logic [NREAD*TAG_W-1:0] rd_tag
);
  logic [XLEN-1:0]  value [NREG];
  logic [TAG_W-1:0] tag   [NREG];
  logic [NREG-1:0]  busy;
  // Commit writes value and releases a matching rename; flush clears busy, otherwise rename claims the register (rename wins over release)
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      for (int i = 0; i < NREG; i++) begin
        value[i] <= '0;
        tag[i]   <= '0;
      end
    end else begin
      if (commit_en && commit_rd != '0) begin
        value[commit_rd] <= commit_value;
        if (busy[commit_rd] && tag[commit_rd] == commit_tag) busy[commit_rd] <= 1'b0;
      end
      if (flush) busy <= '0;
      else if (rename_en && rename_rd != '0) begin
        busy[rename_rd] <= 1'b1;
        tag[rename_rd]  <= rename_tag;
      end
    end
  end
  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0] a;
    logic          live, fwd, rel;
    // Read sees pre-edge rename state; a same-cycle commit to a busy register forwards its value and releases it only on tag match
    always_comb begin
      a    = rd_addr[p*AW +: AW];
      live = !rst && rd_en[p] && a != '0;
      fwd  = live && commit_en && commit_rd == a && busy[a];
      rel  = fwd && tag[a] == commit_tag;
      rd_value[p*XLEN +: XLEN]  = !live ? '0 : fwd ? commit_value : value[a];
      rd_busy[p]                = live && busy[a] && !rel;
      rd_tag[p*TAG_W +: TAG_W]  = (live && !rel) ? tag[a] : '0;
    end
  end
endmodule
